// File: rtl/kbd_display_ctrl.sv
// Pops PS/2 scancode bytes from the receiver FIFO, decodes make/break/extended prefixes,
// and holds the current key, press flag and a two-digit BCD count of distinct presses.
//
// state | meaning
// IDLE  | wait for ready, latch head byte and pop it
// PROC  | apply the byte rule to flags and outputs
// HOLD  | gap cycle so ready can fall after the pop
module kbd_display_ctrl #(
  parameter int TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ready,
  input  logic [7:0] data,
  output logic       nextdata_n,
  output logic       press_flag,
  output logic [3:0] code_hi,
  output logic [3:0] code_lo,
  output logic       extended,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PROC, HOLD} state_t;

  state_t        state;
  logic [7:0]    byte_r;
  logic          brk_pend;
  logic          ext_pend;
  logic [TW-1:0] tmo_cnt;
  logic          accept;
  logic          same_key;

  assign accept   = (state == IDLE) && ready;
  assign same_key = press_flag && (byte_r == {code_hi, code_lo}) && (ext_pend == extended);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      byte_r     <= 8'h00;
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
      tmo_cnt    <= TMO_LOAD;
      nextdata_n <= 1'b1;
      press_flag <= 1'b0;
      code_hi    <= 4'h0;
      code_lo    <= 4'h0;
      extended   <= 1'b0;
      cnt_tens   <= 4'd0;
      cnt_ones   <= 4'd0;
    end else begin
      nextdata_n <= 1'b1;

      // Terminal count with a prefix pending drops the prefix; an accepted byte reloads first.
      if (accept || (!brk_pend && !ext_pend)) begin
        tmo_cnt <= TMO_LOAD;
      end else if (tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - TW'(1);
      end else begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ready) begin
            byte_r     <= data;
            nextdata_n <= 1'b0;
            state      <= PROC;
          end
        end
        PROC: begin
          if (byte_r == 8'hE0) begin
            ext_pend <= 1'b1;
          end else if (byte_r == 8'hF0) begin
            brk_pend <= 1'b1;
          end else if (brk_pend) begin
            if (same_key) press_flag <= 1'b0;
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
          end else begin
            if (!same_key) begin
              code_hi    <= byte_r[7:4];
              code_lo    <= byte_r[3:0];
              extended   <= ext_pend;
              press_flag <= 1'b1;
              if (cnt_ones == 4'd9) begin
                cnt_ones <= 4'd0;
                cnt_tens <= (cnt_tens == 4'd9) ? 4'd0 : cnt_tens + 4'd1;
              end else begin
                cnt_ones <= cnt_ones + 4'd1;
              end
            end
            ext_pend <= 1'b0;
          end
          state <= HOLD;
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_display_ctrl.sv
// Self-checking bench for kbd_display_ctrl: a per-byte key-state model is compared
// against the DUT every cycle, plus literal checkpoints and pop-strobe monitoring.
module tb_kbd_display_ctrl;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       nextdata_n;
  logic       press_flag;
  logic [3:0] code_hi, code_lo, cnt_tens, cnt_ones;
  logic       extended;

  kbd_display_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data),
    .nextdata_n(nextdata_n), .press_flag(press_flag),
    .code_hi(code_hi), .code_lo(code_lo), .extended(extended),
    .cnt_tens(cnt_tens), .cnt_ones(cnt_ones)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Key-state model: applied once per popped byte
  bit         m_press, m_ext, m_brk, m_extp;
  logic [7:0] m_code;
  int         m_count;
  int         m_last_acc;

  bit chk_en = 1'b0;
  bit expect_pop = 1'b0;
  int pops = 0;
  int last_pop = -100;

  logic [17:0] dut_vec;
  assign dut_vec = {press_flag, code_hi, code_lo, extended, cnt_tens, cnt_ones};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [17:0] model_vec();
    return {m_press, m_code, m_ext, 4'(m_count / 10), 4'(m_count % 10)};
  endfunction

  task automatic model_reset();
    m_press = 0; m_ext = 0; m_brk = 0; m_extp = 0;
    m_code = 8'h00; m_count = 0; m_last_acc = -1000;
  endtask

  task automatic model_apply(input logic [7:0] b, input int acc);
    bit same;
    // A prefix left waiting well past the timeout has been discarded
    if ((m_brk || m_extp) && (acc - m_last_acc > TMO + 3)) begin
      m_brk = 0; m_extp = 0;
    end
    m_last_acc = acc;
    same = m_press && (b == m_code) && (m_extp == m_ext);
    if (b == 8'hE0) m_extp = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (m_brk) begin
      if (same) m_press = 0;
      m_brk = 0; m_extp = 0;
    end else begin
      if (!same) begin
        m_code = b; m_ext = m_extp; m_press = 1;
        m_count = (m_count + 1) % 100;
      end
      m_extp = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) check("outputs", 32'(dut_vec), 32'(model_vec()));
  end

  always @(negedge clk) begin
    if (clrn && !nextdata_n) begin
      pops++;
      check("pop_expected", 32'(expect_pop), 32'd1);
      check("pop_spacing", 32'(cyc - last_pop >= 3), 32'd1);
      last_pop = cyc;
      expect_pop = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    int p0;
    int acc;
    bit got;
    @(negedge clk);
    ready = 1; data = b; expect_pop = 1; p0 = pops; got = 0; acc = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      got = (pops != p0);
      acc = cyc;
    end
    ready = 0;
    check("pop_seen", 32'(got), 32'd1);
    if (got) begin
      @(posedge clk);
      model_apply(b, acc);
      #1;
    end else begin
      expect_pop = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    bit got;
    model_reset();
    #23;
    check("rst_outputs", 32'(dut_vec), 32'd0);
    check("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    @(negedge clk); clrn = 1; chk_en = 1;

    idle(100);
    check("no_pop_idle", 32'(pops), 32'd0);

    // Make / break of 1C
    send(8'h1C);
    check("make_1C", 32'(dut_vec), 32'({1'b1, 8'h1C, 1'b0, 4'd0, 4'd1}));
    send(8'hF0);
    send(8'h1C);
    check("break_1C", 32'(dut_vec), 32'({1'b0, 8'h1C, 1'b0, 4'd0, 4'd1}));
    check("pop_count_3", 32'(pops), 32'd3);

    // Typematic repeats then a new key
    send(8'h1C); send(8'h1C); send(8'h1C);
    check("repeat_1C", 32'(dut_vec), 32'({1'b1, 8'h1C, 1'b0, 4'd0, 4'd2}));
    send(8'h32);
    check("make_32", 32'(dut_vec), 32'({1'b1, 8'h32, 1'b0, 4'd0, 4'd3}));
    send(8'hF0); send(8'h32);

    // Extended key: unprefixed break must not release it
    send(8'hE0); send(8'h75);
    check("make_E075", 32'(dut_vec), 32'({1'b1, 8'h75, 1'b1, 4'd0, 4'd4}));
    send(8'hF0); send(8'h75);
    check("plain_break_ignored", 32'(press_flag), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_break", 32'(press_flag), 32'd0);

    // Count wrap: starts at 04, 95 presses reach 99, the 96th wraps to 00
    for (int i = 0; i < 100; i++) begin
      send(8'h29);
      if (i == 94) check("count_99", 32'({cnt_tens, cnt_ones}), 32'h99);
      if (i == 95) check("count_wrap", 32'({cnt_tens, cnt_ones}), 32'h00);
      if (i == 5)  check("count_10", 32'({cnt_tens, cnt_ones}), 32'h10);
      send(8'hF0); send(8'h29);
    end
    check("count_after_100", 32'({cnt_tens, cnt_ones}), 32'h04);

    // Stale break prefix times out; following 1C is a repeat of the held key
    send(8'h1C);
    send(8'hF0);
    idle(10);
    send(8'h1C);
    check("timeout_repeat", 32'(dut_vec), 32'({1'b1, 8'h1C, 1'b0, 4'd0, 4'd5}));

    // Reset asserted while the DUT is in PROC
    @(negedge clk);
    ready = 1; data = 8'h5A; expect_pop = 1; p0 = pops; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      got = (pops != p0);
    end
    check("pop_before_reset", 32'(got), 32'd1);
    chk_en = 0;
    clrn = 0; ready = 0; expect_pop = 0;
    #1;
    check("async_rst_outputs", 32'(dut_vec), 32'd0);
    check("async_rst_nextdata_n", 32'(nextdata_n), 32'd1);
    model_reset();
    @(negedge clk); clrn = 1; chk_en = 1;
    idle(5);
    check("lost_byte", 32'(dut_vec), 32'd0);
    send(8'h5A);
    check("make_after_reset", 32'(dut_vec), 32'({1'b1, 8'h5A, 1'b0, 4'd0, 4'd1}));
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
